instr_prefetch_unit: RTL

- Instruction fetch front-end between the BU2020 core's decode stage and the Memory instruction port (Instruction_addressbus / Instruction_databus).
- Generates sequential fetch addresses, captures returned 16-bit instruction words into a small queue, and presents them to decode with a valid/ready handshake.
- Supports a redirect (branch/jump) from the core that flushes everything in flight.

---
 rtl/bu2020_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_prefetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/bu2020_pkg.sv
// Shared constants for the BU2020 instruction fetch path.
//   ADDR_W      : instruction address width (byte address)
//   DATA_W      : instruction word width
//   INSTR_BYTES : bytes per instruction word (fetch address stride)
//   RESET_PC    : default first fetch address after reset
package bu2020_pkg;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int INSTR_BYTES = 2;

  localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, word} entries for the prefetch unit.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop all entries (same effect as reset, pointers to 0)
//   push, wr_data : enqueue one entry (ignored when full)
//   pop           : dequeue the head (ignored when empty)
//   head          : head entry, reads 0 while empty
//   count         : number of stored entries (0..DEPTH)
//   full, empty   : occupancy flags
module fetch_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage is not reset; the empty gate below keeps stale contents invisible.
  always_ff @(posedge clk) begin
    if (push_ok && !rst && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch front-end: issues sequential fetch addresses to a
// 1-cycle-latency instruction memory, queues the returned words with their
// addresses, and hands them to decode over a valid/ready handshake.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : fetch address (byte address, always even)
//   imem_data       : word for the address driven in the previous cycle
//   redirect_valid  : restart fetch stream, flushing everything in flight
//   redirect_pc     : new fetch address (bit 0 ignored)
//   instr_valid     : queue head valid
//   instr_ready     : decode accepts the head
//   instr, instr_pc : head word and the address it came from
module instr_prefetch_unit #(
  parameter int                 DEPTH    = 4,
  parameter int                 ADDR_W   = bu2020_pkg::ADDR_W,
  parameter int                 DATA_W   = bu2020_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = bu2020_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  import bu2020_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_pc;
  logic              pending;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    in_flight;
  logic              issue;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] redirect_target;

  // Credit counts entries already queued plus the word still in the memory
  // pipeline; a pop this cycle is deliberately not credited.
  assign in_flight = {1'b0, count} + (CNT_W + 1)'(pending);
  assign issue     = (in_flight < (CNT_W + 1)'(DEPTH)) && !redirect_valid;
  // The credit rule means full is never seen here; the guard is belt-and-braces.
  assign push      = pending && !redirect_valid && !full;
  assign pop       = instr_valid && instr_ready && !redirect_valid;

  assign redirect_target = redirect_pc & ~ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc         <= redirect_target;
      pending    <= 1'b0;
      pending_pc <= pending_pc;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= pc;
        pc         <= pc + ADDR_W'(INSTR_BYTES);
      end
    end
  end

  assign imem_addr = pc;

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .push    (push),
    .wr_data ({pending_pc, imem_data}),
    .pop     (pop),
    .head    ({instr_pc, instr}),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign instr_valid = !empty;

endmodule
